// File: rtl/verisparse_pkg.sv
// Shared definitions for the matching-pursuit datapath: RAM geometry shared
// between the loader and the PE, the data word type and the loader states.
package verisparse_pkg;

   localparam int SIGNAL_ADDR_WIDTH         = 8;
   localparam int DICTIONARY_ADDR_WIDTH     = 12;
   localparam int REPRESENTATION_ADDR_WIDTH = 6;
   localparam int DATA_WIDTH                = 8;

   typedef logic [DATA_WIDTH-1:0] byte_t;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR_X,
      LOAD_Y,
      LOAD_DICT,
      DONE
   } mp_loader_state_t;

endpackage

// File: rtl/mp_stream_ram_writer.sv
// Writes one segment of the input byte stream into a RAM. The address
// advances per accepted byte; each accepted byte becomes a registered
// one-cycle write on the following cycle. done marks acceptance of the
// segment's final byte; last_mismatch flags in_last disagreeing with whether
// that byte ends the whole load.
module mp_stream_ram_writer #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  enable,
   input  logic [ADDR_WIDTH:0]   len,
   input  logic                  final_seg,
   input  logic                  hs,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  done,
   output logic                  last_mismatch
);

   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  accept;
   logic                  is_final;

   // Byte acceptance, end-of-segment detection and next write-port values.
   // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      accept        = enable & hs;
      // Compare in len's own width so a full-capacity length ends on the top address.
      is_final      = ({1'b0, cnt_q} == (len - (ADDR_WIDTH+1)'(1)));
      done          = accept & is_final;
      last_mismatch = accept & (in_last != (is_final & final_seg));
      cnt_d         = cnt_q;
      we_d          = accept;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      if (!enable) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d   = cnt_q + ADDR_WIDTH'(1);
         addr_d  = cnt_q;
         wdata_d = in_data;
      end
   end

   // Counter and registered write port, synchronously cleared.
   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign we    = we_q;
   assign addr  = addr_q;
   assign wdata = wdata_q;

endmodule

// File: rtl/mp_ram_loader.sv
// Loads the matching-pursuit PE memories: zeroes x, streams y then the
// dictionary from one byte stream, then pulses mp_start.
// Optional feature: define MP_LOADER_CHECKSUM_EN to build the 16-bit running
// byte sum on checksum; otherwise checksum is tied to zero.
module mp_ram_loader #(
   parameter int SIGNAL_ADDR_WIDTH         = verisparse_pkg::SIGNAL_ADDR_WIDTH,
   parameter int DICTIONARY_ADDR_WIDTH     = verisparse_pkg::DICTIONARY_ADDR_WIDTH,
   parameter int REPRESENTATION_ADDR_WIDTH = verisparse_pkg::REPRESENTATION_ADDR_WIDTH,
   parameter int DATA_WIDTH                = verisparse_pkg::DATA_WIDTH
) (
   input  logic                                 clock,
   input  logic                                 resetN,
   input  logic                                 load_start,
   input  logic [SIGNAL_ADDR_WIDTH:0]           y_len,
   input  logic [DICTIONARY_ADDR_WIDTH:0]       dict_len,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [DATA_WIDTH-1:0]                in_data,
   input  logic                                 in_last,
   output logic                                 x_we,
   output logic [REPRESENTATION_ADDR_WIDTH-1:0] x_addr,
   output logic [DATA_WIDTH-1:0]                x_wdata,
   output logic                                 y_we,
   output logic [SIGNAL_ADDR_WIDTH-1:0]         y_addr,
   output logic [DATA_WIDTH-1:0]                y_wdata,
   output logic                                 dict_we,
   output logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_addr,
   output logic [DATA_WIDTH-1:0]                dict_wdata,
   output logic                                 busy,
   output logic                                 mp_start,
   output logic                                 load_err,
   output logic [15:0]                          checksum
);

   import verisparse_pkg::*;

   localparam logic [SIGNAL_ADDR_WIDTH:0]     Y_CAP = {1'b1, {SIGNAL_ADDR_WIDTH{1'b0}}};
   localparam logic [DICTIONARY_ADDR_WIDTH:0] D_CAP = {1'b1, {DICTIONARY_ADDR_WIDTH{1'b0}}};

   mp_loader_state_t                     state_q, state_d;
   logic [SIGNAL_ADDR_WIDTH:0]           y_len_q, y_len_d;
   logic [DICTIONARY_ADDR_WIDTH:0]       dict_len_q, dict_len_d;
   logic [REPRESENTATION_ADDR_WIDTH-1:0] x_cnt_q, x_cnt_d;
   logic [REPRESENTATION_ADDR_WIDTH-1:0] x_addr_q, x_addr_d;
   logic                                 x_we_q, x_we_d;
   logic                                 load_err_q, load_err_d;
   logic                                 busy_q, busy_d;
   logic                                 mp_start_q, mp_start_d;
   logic                                 in_ready_q, in_ready_d;
   logic                                 start_ok;
   logic                                 byte_acc;
   logic                                 y_done, y_mis, d_done, d_mis;

   // in_ready is a flop, so the handshake never loops through in_valid.
   assign byte_acc = in_valid & in_ready_q;

   mp_stream_ram_writer #(
      .ADDR_WIDTH (SIGNAL_ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_y_writer (
      .clock         (clock),
      .resetN        (resetN),
      .enable        (state_q == LOAD_Y),
      .len           (y_len_q),
      .final_seg     (dict_len_q == '0),
      .hs            (byte_acc),
      .in_data       (in_data),
      .in_last       (in_last),
      .we            (y_we),
      .addr          (y_addr),
      .wdata         (y_wdata),
      .done          (y_done),
      .last_mismatch (y_mis)
   );

   mp_stream_ram_writer #(
      .ADDR_WIDTH (DICTIONARY_ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_dict_writer (
      .clock         (clock),
      .resetN        (resetN),
      .enable        (state_q == LOAD_DICT),
      .len           (dict_len_q),
      .final_seg     (1'b1),
      .hs            (byte_acc),
      .in_data       (in_data),
      .in_last       (in_last),
      .we            (dict_we),
      .addr          (dict_addr),
      .wdata         (dict_wdata),
      .done          (d_done),
      .last_mismatch (d_mis)
   );

   // Next-state logic and registered, state-decoded outputs.
   always_comb begin
      state_d    = state_q;
      y_len_d    = y_len_q;
      dict_len_d = dict_len_q;
      x_cnt_d    = x_cnt_q;
      x_addr_d   = x_addr_q;
      x_we_d     = 1'b0;
      load_err_d = load_err_q;
      start_ok   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (load_start) begin
               if ((y_len > Y_CAP) || (dict_len > D_CAP)) begin
                  load_err_d = 1'b1;
               end else begin
                  start_ok   = 1'b1;
                  load_err_d = 1'b0;
                  y_len_d    = y_len;
                  dict_len_d = dict_len;
                  x_cnt_d    = '0;
                  state_d    = CLEAR_X;
               end
            end
         end
         CLEAR_X: begin
            x_we_d   = 1'b1;
            x_addr_d = x_cnt_q;
            x_cnt_d  = x_cnt_q + REPRESENTATION_ADDR_WIDTH'(1);
            if (&x_cnt_q) begin
               if (y_len_q != '0)         state_d = LOAD_Y;
               else if (dict_len_q != '0) state_d = LOAD_DICT;
               else                       state_d = DONE;
            end
         end
         LOAD_Y: begin
            // An early in_last still writes its byte, then abandons the load.
            if (y_mis && in_last) begin
               load_err_d = 1'b1;
               state_d    = IDLE;
            end else if (y_done) begin
               if (y_mis) load_err_d = 1'b1;
               state_d = (dict_len_q != '0) ? LOAD_DICT : DONE;
            end
         end
         LOAD_DICT: begin
            if (d_mis && in_last) begin
               load_err_d = 1'b1;
               state_d    = IDLE;
            end else if (d_done) begin
               if (d_mis) load_err_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d     = (state_d != IDLE);
      mp_start_d = (state_d == DONE);
      in_ready_d = (state_d == LOAD_Y) || (state_d == LOAD_DICT);
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q    <= IDLE;
         y_len_q    <= '0;
         dict_len_q <= '0;
         x_cnt_q    <= '0;
         x_addr_q   <= '0;
         x_we_q     <= 1'b0;
         load_err_q <= 1'b0;
         busy_q     <= 1'b0;
         mp_start_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_len_q    <= y_len_d;
         dict_len_q <= dict_len_d;
         x_cnt_q    <= x_cnt_d;
         x_addr_q   <= x_addr_d;
         x_we_q     <= x_we_d;
         load_err_q <= load_err_d;
         busy_q     <= busy_d;
         mp_start_q <= mp_start_d;
         in_ready_q <= in_ready_d;
      end
   end

`ifdef MP_LOADER_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   // Running sum of accepted bytes; lands with the matching RAM write.
   always_comb begin
      checksum_d = checksum_q;
      if (byte_acc) checksum_d = checksum_q + 16'(in_data);
      if (start_ok) checksum_d = '0;
   end

   // Checksum register, held after the load completes.
   always_ff @(posedge clock) begin
      if (!resetN) checksum_q <= '0;
      else         checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

   assign in_ready = in_ready_q;
   assign x_we     = x_we_q;
   assign x_addr   = x_addr_q;
   assign x_wdata  = '0;
   assign busy     = busy_q;
   assign mp_start = mp_start_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_mp_ram_loader.sv
// Self-checking bench for mp_ram_loader: a table of stream loads with
// hand-computed outcomes, plus directed length-error and mid-load reset cases.
module tb_mp_ram_loader;

   logic        clock = 1'b0;
   logic        resetN;
   logic        load_start;
   logic [8:0]  y_len;
   logic [12:0] dict_len;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        x_we, y_we, dict_we;
   logic [5:0]  x_addr;
   logic [7:0]  y_addr;
   logic [11:0] dict_addr;
   logic [7:0]  x_wdata, y_wdata, dict_wdata;
   logic        busy, mp_start, load_err;
   logic [15:0] checksum;

   int checks = 0;
   int errors = 0;

   // Write-port monitor state, cleared whenever load_start is driven.
   int         x_cnt, y_cnt, d_cnt, mps_cnt, addr_err, y_last;
   logic       rdy_seen, busy_seen;
   logic [7:0] ymem [256];
   logic [7:0] dmem [4096];

   typedef struct {
      int          yl;
      int          dl;
      int          lastp;   // 1-based byte carrying in_last, 0 = never
      int          gap;     // 1 = in_valid low every other cycle
      logic        exp_err;
      int          exp_mps;
      logic [15:0] exp_cks;
   } vec_t;

   always #5 clock = ~clock;

   mp_ram_loader dut (
      .clock      (clock),
      .resetN     (resetN),
      .load_start (load_start),
      .y_len      (y_len),
      .dict_len   (dict_len),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .x_we       (x_we),
      .x_addr     (x_addr),
      .x_wdata    (x_wdata),
      .y_we       (y_we),
      .y_addr     (y_addr),
      .y_wdata    (y_wdata),
      .dict_we    (dict_we),
      .dict_addr  (dict_addr),
      .dict_wdata (dict_wdata),
      .busy       (busy),
      .mp_start   (mp_start),
      .load_err   (load_err),
      .checksum   (checksum)
   );

   always @(posedge clock) begin
      #1;
      if (load_start) begin
         x_cnt     <= 0;
         y_cnt     <= 0;
         d_cnt     <= 0;
         mps_cnt   <= 0;
         addr_err  <= 0;
         y_last    <= -1;
         rdy_seen  <= 1'b0;
         busy_seen <= 1'b0;
         for (int i = 0; i < 256; i++)  ymem[i] <= 8'hEE;
         for (int i = 0; i < 4096; i++) dmem[i] <= 8'hEE;
      end else begin
         if (x_we) begin
            if (x_addr != x_cnt[5:0] || x_wdata != 8'h00) addr_err <= addr_err + 1;
            x_cnt <= x_cnt + 1;
         end
         if (y_we) begin
            if (y_addr != y_cnt[7:0]) addr_err <= addr_err + 1;
            ymem[y_addr] <= y_wdata;
            y_last       <= int'(y_addr);
            y_cnt        <= y_cnt + 1;
         end
         if (dict_we) begin
            if (dict_addr != d_cnt[11:0]) addr_err <= addr_err + 1;
            dmem[dict_addr] <= dict_wdata;
            d_cnt           <= d_cnt + 1;
         end
         if (mp_start) mps_cnt <= mps_cnt + 1;
         if (in_ready) rdy_seen <= 1'b1;
         if (busy)     busy_seen <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int stop_point(input vec_t v);
      int total = v.yl + v.dl;
      return (v.lastp != 0 && v.lastp < total) ? v.lastp : total;
   endfunction

   task automatic pulse_start(input int yl, input int dl);
      @(negedge clock);
      load_start = 1'b1;
      y_len      = 9'(yl);
      dict_len   = 13'(dl);
      @(negedge clock);
      load_start = 1'b0;
   endtask

   // Streams bytes 1,2,3,... until the load should end, then waits for idle.
   task automatic run_load(input vec_t v, input string tag);
      int  stop_at, k, cyc;
      bit  acc, tog;
      stop_at = stop_point(v);
      pulse_start(v.yl, v.dl);
      k = 0; cyc = 0; tog = 1'b0;
      while (k < stop_at && cyc < 3000) begin
         if (v.gap != 0 && tog) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = 8'(k + 1);
            in_last  = (k + 1 == v.lastp);
         end
         tog = !tog;
         acc = in_valid && in_ready;
         @(negedge clock);
         cyc++;
         if (acc) k++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check({tag, "_bytes_taken"}, k, stop_at);
      cyc = 0;
      while (busy && cyc < 3000) begin
         @(negedge clock);
         cyc++;
      end
      check({tag, "_busy_drop"}, busy, 1'b0);
      repeat (3) @(negedge clock);
   endtask

   task automatic run_and_check(input vec_t v, input string tag);
      int          stop_at, y_exp, d_exp, bad;
      logic [15:0] cks_exp;
      run_load(v, tag);
      stop_at = stop_point(v);
      y_exp   = (stop_at < v.yl) ? stop_at : v.yl;
      d_exp   = (stop_at > v.yl) ? stop_at - v.yl : 0;
`ifdef MP_LOADER_CHECKSUM_EN
      cks_exp = v.exp_cks;
`else
      cks_exp = 16'h0000;
`endif
      check({tag, "_load_err"}, load_err, v.exp_err);
      check({tag, "_mp_start"}, mps_cnt, v.exp_mps);
      check({tag, "_x_writes"}, x_cnt, 64);
      check({tag, "_y_writes"}, y_cnt, y_exp);
      check({tag, "_dict_writes"}, d_cnt, d_exp);
      check({tag, "_addr_seq"}, addr_err, 0);
      check({tag, "_in_ready_seen"}, rdy_seen, stop_at > 0);
      check({tag, "_checksum"}, checksum, cks_exp);
      bad = 0;
      for (int i = 0; i < y_exp; i++) if (ymem[i] !== 8'(i + 1)) bad++;
      check({tag, "_y_data_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < d_exp; i++) if (dmem[i] !== 8'(v.yl + i + 1)) bad++;
      check({tag, "_dict_data_bad"}, bad, 0);
      if (y_exp > 0) check({tag, "_y_top_addr"}, y_last, y_exp - 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [9];
      int   snap_w, snap_m, k, cyc;
      bit   acc;

      //          yl   dl  lastp gap err mps cks
      vecs[0] = '{4,   8,  12,   0,  0,  1,  16'h004E};
      vecs[1] = '{4,   8,  12,   1,  0,  1,  16'h004E};
      vecs[2] = '{4,   8,  6,    0,  1,  0,  16'h0015};
      vecs[3] = '{4,   8,  12,   0,  0,  1,  16'h004E};
      vecs[4] = '{0,   0,  0,    0,  0,  1,  16'h0000};
      vecs[5] = '{3,   0,  0,    0,  1,  1,  16'h0006};
      vecs[6] = '{0,   2,  2,    0,  0,  1,  16'h0003};
      vecs[7] = '{4,   8,  4,    0,  1,  0,  16'h000A};
      vecs[8] = '{256, 1,  257,  0,  0,  1,  16'h7F81};

      resetN     = 1'b0;
      load_start = 1'b0;
      y_len      = '0;
      dict_len   = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_busy", busy, 1'b0);
      check("rst_load_err", load_err, 1'b0);
      check("rst_mp_start", mp_start, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_we", {x_we, y_we, dict_we}, 3'b000);
      check("rst_addr", {x_addr, y_addr, dict_addr}, 26'd0);
      check("rst_wdata", {x_wdata, y_wdata, dict_wdata}, 24'd0);
      check("rst_checksum", checksum, 16'h0000);
      resetN = 1'b1;

      // Oversized lengths are refused without writing anything.
      pulse_start(257, 8);
      repeat (5) @(negedge clock);
      check("len_y_err", load_err, 1'b1);
      check("len_y_busy", busy_seen, 1'b0);
      check("len_y_writes", x_cnt + y_cnt + d_cnt, 0);
      pulse_start(4, 4097);
      repeat (5) @(negedge clock);
      check("len_d_err", load_err, 1'b1);
      check("len_d_busy", busy_seen, 1'b0);
      check("len_d_writes", x_cnt + y_cnt + d_cnt, 0);

      for (int i = 0; i < 9; i++) run_and_check(vecs[i], $sformatf("v%0d", i));

      // Reset while a dictionary byte is being offered.
      pulse_start(4, 8);
      k = 0; cyc = 0;
      while (k < 6 && cyc < 500) begin
         in_valid = 1'b1;
         in_data  = 8'(k + 1);
         in_last  = 1'b0;
         acc      = in_ready;
         @(negedge clock);
         cyc++;
         if (acc) k++;
      end
      check("mid_rst_dict_before", d_cnt, 2);
      in_data = 8'd7;
      resetN  = 1'b0;
      @(negedge clock);
      resetN   = 1'b1;
      in_valid = 1'b0;
      check("mid_rst_we", {x_we, y_we, dict_we}, 3'b000);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      check("mid_rst_checksum", checksum, 16'h0000);
      snap_w = x_cnt + y_cnt + d_cnt;
      snap_m = mps_cnt;
      repeat (50) @(negedge clock);
      check("mid_rst_no_writes", x_cnt + y_cnt + d_cnt, snap_w);
      check("mid_rst_no_mp_start", mps_cnt, snap_m);
      check("mid_rst_dict_after", d_cnt, 2);
      run_and_check(vecs[0], "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
